pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 8-bit five-stage core. It decides every cycle whether the PC and IF/ID register advance, hold or flush, and whether ID/EX receives a bubble. It drives the `hazard` input of the IF/ID stage register and the PC-select mux from three sources: load-use dependencies, taken branches resolved in EX, and data-memory wait states. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 30 +++
 rtl/pipeline_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the FSM state encoding, the NOP encoding, the default register-address
// width and the PC width used by the controller and its comparator.
package pipe_pkg;

  localparam int          RAW_DEF = 3;
  localparam int          PC_W    = 8;
  localparam logic [7:0]  NOP     = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Ports:
//   i_idex_mem_read        - instruction in EX is a load
//   i_idex_rd              - destination register of the EX instruction
//   i_ifid_rs1/_rs2        - source registers of the ID instruction
//   i_ifid_use_rs1/_rs2    - ID instruction actually reads that source
//   o_hit                  - ID instruction depends on the load in EX
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int RAW = RAW_DEF
) (
  input  logic           i_idex_mem_read,
  input  logic [RAW-1:0] i_idex_rd,
  input  logic [RAW-1:0] i_ifid_rs1,
  input  logic [RAW-1:0] i_ifid_rs2,
  input  logic           i_ifid_use_rs1,
  input  logic           i_ifid_use_rs2,
  output logic           o_hit
);

  logic w_rs1_match;
  logic w_rs2_match;

  // Register 0 is an ordinary register on this core, so no zero exclusion.
  assign w_rs1_match = i_ifid_use_rs1 && (i_ifid_rs1 == i_idex_rd);
  assign w_rs2_match = i_ifid_use_rs2 && (i_ifid_rs2 == i_idex_rd);
  assign o_hit       = i_idex_mem_read && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 8-bit five-stage core.
// Decides each cycle whether PC and IF/ID advance, hold or flush, whether
// ID/EX takes a bubble, and whether the back end freezes for memory waits.
// Ports:
//   i_clk, i_rst_n              - clock, async active-low reset
//   i_ifid_*                    - ID instruction source registers and use flags
//   i_idex_mem_read, i_idex_rd  - EX instruction load flag and destination
//   i_branch_taken/_target      - taken branch resolved in EX and its target
//   i_mem_busy                  - data memory not ready
//   o_pc_hold, o_ifid_hazard, o_ifid_flush, o_idex_bubble, o_pipe_freeze,
//   o_pc_sel, o_pc_redirect     - Mealy control outputs
//   o_stall_cnt, o_flush_cnt    - saturating statistics counters
//   o_mem_timeout               - sticky memory-wait timeout flag
//   o_state                     - current FSM state
//
// state       | meaning
// ------------+-------------------------------------------------------------
// RUN         | normal flow; branch / load-use evaluated every cycle
// LU_STALL    | one-cycle load-use stall; load-use detection suppressed
// MEM_WAIT    | back end frozen while data memory is busy
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int RAW      = RAW_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [RAW-1:0]  i_ifid_rs1,
  input  logic [RAW-1:0]  i_ifid_rs2,
  input  logic            i_ifid_use_rs1,
  input  logic            i_ifid_use_rs2,
  input  logic            i_idex_mem_read,
  input  logic [RAW-1:0]  i_idex_rd,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  input  logic            i_mem_busy,
  output logic            o_pc_hold,
  output logic            o_ifid_hazard,
  output logic            o_ifid_flush,
  output logic            o_idex_bubble,
  output logic            o_pipe_freeze,
  output logic            o_pc_sel,
  output logic [PC_W-1:0] o_pc_redirect,
  output logic [15:0]     o_stall_cnt,
  output logic [7:0]      o_flush_cnt,
  output logic            o_mem_timeout,
  output logic [1:0]      o_state
);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_flush_cnt;
  logic        r_mem_timeout;

  state_t      w_next;
  logic [7:0]  w_wait_nxt;
  logic        w_to_set;
  logic        w_eval_run;
  logic        w_lu_hit;
  logic        w_pc_hold;
  logic        w_ifid_hazard;
  logic        w_ifid_flush;
  logic        w_idex_bubble;
  logic        w_pipe_freeze;
  logic        w_pc_sel;
  logic [8:0]  w_wait_inc;

  hazard_detect #(.RAW(RAW)) u_hazard_detect (
    .i_idex_mem_read (i_idex_mem_read),
    .i_idex_rd       (i_idex_rd),
    .i_ifid_rs1      (i_ifid_rs1),
    .i_ifid_rs2      (i_ifid_rs2),
    .i_ifid_use_rs1  (i_ifid_use_rs1),
    .i_ifid_use_rs2  (i_ifid_use_rs2),
    .o_hit           (w_lu_hit)
  );

  // Unsaturated increment so "would exceed MAX_WAIT" still works at 255.
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

  always_comb begin
    w_next        = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_to_set      = 1'b0;
    w_eval_run    = 1'b0;
    w_pc_hold     = 1'b0;
    w_ifid_hazard = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_freeze = 1'b0;
    w_pc_sel      = 1'b0;
    // Outputs are Mealy; gating with reset keeps them quiet while reset is held.
    if (i_rst_n) begin
      case (r_state)
        ST_RUN, ST_LU_STALL: begin
          if (i_mem_busy) begin
            w_pc_hold     = 1'b1;
            w_ifid_hazard = 1'b1;
            w_pipe_freeze = 1'b1;
            w_next        = ST_MEM_WAIT;
            w_wait_nxt    = 8'd1;
          end else if (r_state == ST_LU_STALL) begin
            w_next = ST_RUN;
          end else begin
            w_eval_run = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_busy) begin
            w_pc_hold     = 1'b1;
            w_ifid_hazard = 1'b1;
            w_pipe_freeze = 1'b1;
            w_wait_nxt    = (r_wait_cnt == 8'hFF) ? 8'hFF : w_wait_inc[7:0];
            w_to_set      = (w_wait_inc > 9'(MAX_WAIT));
          end else begin
            w_next     = ST_RUN;
            w_wait_nxt = 8'd0;
            w_eval_run = 1'b1;
          end
        end
        default: begin
          w_next     = ST_RUN;
          w_wait_nxt = 8'd0;
        end
      endcase

      // A branch flushes the ID instruction, so its load-use hit is wrong-path.
      if (w_eval_run) begin
        if (i_branch_taken) begin
          w_pc_sel      = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (w_lu_hit) begin
          w_pc_hold     = 1'b1;
          w_ifid_hazard = 1'b1;
          w_idex_bubble = 1'b1;
          w_next        = ST_LU_STALL;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_stall_cnt   <= 16'd0;
      r_flush_cnt   <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (w_pc_hold && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_pc_sel && (r_flush_cnt != 8'hFF)) begin
        r_flush_cnt <= r_flush_cnt + 8'd1;
      end
      if (w_to_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign o_pc_hold     = w_pc_hold;
  assign o_ifid_hazard = w_ifid_hazard;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_pipe_freeze = w_pipe_freeze;
  assign o_pc_sel      = w_pc_sel;
  assign o_pc_redirect = w_pc_sel ? i_branch_target : '0;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_mem_timeout = r_mem_timeout;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_use_rs1, ifid_use_rs2, idex_mem_read;
  logic        branch_taken, mem_busy;
  logic [7:0]  branch_target;
  logic        pc_hold, ifid_hazard, ifid_flush, idex_bubble, pipe_freeze, pc_sel;
  logic [7:0]  pc_redirect;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
  logic        mem_timeout;
  logic [1:0]  state;

  int n_chk;
  int n_err;
  int exp_stall;

  pipeline_ctrl #(.RAW(3), .MAX_WAIT(15)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ifid_rs1      (ifid_rs1),
    .i_ifid_rs2      (ifid_rs2),
    .i_ifid_use_rs1  (ifid_use_rs1),
    .i_ifid_use_rs2  (ifid_use_rs2),
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rd       (idex_rd),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_mem_busy      (mem_busy),
    .o_pc_hold       (pc_hold),
    .o_ifid_hazard   (ifid_hazard),
    .o_ifid_flush    (ifid_flush),
    .o_idex_bubble   (idex_bubble),
    .o_pipe_freeze   (pipe_freeze),
    .o_pc_sel        (pc_sel),
    .o_pc_redirect   (pc_redirect),
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt),
    .o_mem_timeout   (mem_timeout),
    .o_state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0; idex_mem_read = 0;
    branch_taken = 0; mem_busy = 0; branch_target = '0;
  endtask

  // Check the full control vector: {hold,hazard,flush,bubble,freeze,sel}.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, int'({pc_hold, ifid_hazard, ifid_flush, idex_bubble, pipe_freeze, pc_sel}),
        int'(exp));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clear_in();
    rst_n = 1'b0;
    #22;
    chk("rst_state", int'(state), 0);
    chk_ctl("rst_ctl", 6'b000000);
    chk("rst_cnts", int'({stall_cnt, flush_cnt, 7'd0, mem_timeout}), 0);
    step();
    rst_n = 1'b1;
    step();

    // Load-use on rs2.
    idex_mem_read = 1; idex_rd = 3'd3; ifid_rs2 = 3'd3; ifid_use_rs2 = 1;
    #1;
    chk_ctl("lu_ctl", 6'b110100);
    chk("lu_state0", int'(state), 0);
    step();
    chk("lu_state1", int'(state), 1);
    chk_ctl("lu_supp", 6'b000000);
    clear_in();
    step();
    chk("lu_back_run", int'(state), 0);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    exp_stall = 1;

    // use flag gates the match
    idex_mem_read = 1; idex_rd = 3'd5; ifid_rs1 = 3'd5; ifid_use_rs1 = 0;
    #1;
    chk_ctl("lu_nouse", 6'b000000);
    clear_in();

    // Branch with coincident load-use hit.
    branch_taken = 1; branch_target = 8'h42;
    idex_mem_read = 1; idex_rd = 3'd3; ifid_rs2 = 3'd3; ifid_use_rs2 = 1;
    #1;
    chk_ctl("br_ctl", 6'b001101);
    chk("br_redirect", int'(pc_redirect), 8'h42);
    step();
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_state", int'(state), 0);
    clear_in();
    branch_target = 8'h42;
    #1;
    chk("nobr_redirect", int'(pc_redirect), 0);

    // Memory wait of 4 with a branch held throughout.
    mem_busy = 1; branch_taken = 1; branch_target = 8'h42;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("mw_frz%0d", i), 6'b110010);
      step();
    end
    mem_busy = 0;
    #1;
    chk("mw_state", int'(state), 2);
    chk_ctl("mw_release", 6'b001101);
    chk("mw_redirect", int'(pc_redirect), 8'h42);
    step();
    exp_stall += 4;
    chk("mw_stall_cnt", int'(stall_cnt), exp_stall);
    chk("mw_flush_cnt", int'(flush_cnt), 2);
    chk("mw_state_run", int'(state), 0);
    chk("mw_no_to", int'(mem_timeout), 0);
    clear_in();

    // Timeout after 16 busy cycles.
    mem_busy = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 14) chk("to_at15", int'(mem_timeout), 0);
    end
    chk("to_at16", int'(mem_timeout), 1);
    mem_busy = 0;
    step();
    exp_stall += 16;
    chk("to_sticky", int'(mem_timeout), 1);
    chk("to_state", int'(state), 0);
    chk("to_stall_cnt", int'(stall_cnt), exp_stall);

    // Register 0 is an ordinary register.
    idex_mem_read = 1; idex_rd = 3'd0; ifid_rs1 = 3'd0; ifid_use_rs1 = 1;
    #1;
    chk_ctl("lu_r0", 6'b110100);
    step();
    clear_in();
    step();
    exp_stall += 1;
    chk("lu_r0_stall", int'(stall_cnt), exp_stall);

    // Asynchronous reset mid-MEM_WAIT.
    mem_busy = 1;
    step();
    step();
    chk("pre_rst_state", int'(state), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk_ctl("arst_ctl", 6'b000000);
    chk("arst_cnts", int'({stall_cnt, flush_cnt, 7'd0, mem_timeout}), 0);
    step();
    rst_n = 1'b1;
    mem_busy = 0;
    step();

    // Flush counter saturation.
    branch_taken = 1; branch_target = 8'h10;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) chk("sat_254", int'(flush_cnt), 254);
    end
    chk("sat_ff", int'(flush_cnt), 255);
    chk("sat_no_stall", int'(stall_cnt), 0);
    clear_in();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
